// File: rtl/wiscsc15_pkg.sv
// Shared WISC-SC15 constants: datapath widths, decoder-visible opcodes and
// the fetch FSM state encoding.
package wiscsc15_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    // Opcodes the fetch stage and the control decoder agree on.
    localparam logic [3:0] OP_BRANCH = 4'b1100;
    localparam logic [3:0] OP_CALL   = 4'b1101;
    localparam logic [3:0] OP_RET    = 4'b1110;
    localparam logic [3:0] OP_HALT   = 4'b1111;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/wiscsc15_fetch_if.sv
// Instruction-memory request/valid channel between the fetch stage (master)
// and instruction memory (slave).
interface wiscsc15_fetch_if #(
    parameter int PC_W    = wiscsc15_pkg::PC_W,
    parameter int INSTR_W = wiscsc15_pkg::INSTR_W
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/wiscsc15_pc_reg.sv
// Program counter: synchronous reset to RESET_PC, redirect load, and
// wrap-around increment.
module wiscsc15_pc_reg #(
    parameter int              PC_W     = wiscsc15_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1
);
    // Truncation to PC_W bits gives the modulo-2^PC_W wrap.
    assign pc_plus1 = pc + PC_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every reader
    // in the same edge sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc_plus1;
        end
    end
endmodule

// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 instruction fetch stage: PC, IR and variable-latency imem
// handshake. Define FETCH_PERF_CNT_EN to add fetch/redirect counters.
module wiscsc15_fetch #(
    parameter int              PC_W     = wiscsc15_pkg::PC_W,
    parameter int              INSTR_W  = wiscsc15_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        fetch_count,
    output logic [31:0]        redirect_count,
`endif
    wiscsc15_fetch_if.master   imem,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus1,
    input  logic               instr_ack,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted
);
    import wiscsc15_pkg::*;

    fetch_state_e       state;
    fetch_state_e       state_next;
    logic               pending;
    logic               pending_next;
    logic               ir_load;
    logic               pc_load;
    logic               pc_inc;
    logic [INSTR_W-1:0] ir;

    wiscsc15_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (redirect_pc),
        .inc      (pc_inc),
        .pc       (pc),
        .pc_plus1 (pc_plus1)
    );

    // The reset state is REQ; gating with rst keeps the request quiet while
    // reset is held so the first pulse lands in the first cycle after release.
    assign imem.imem_req  = (state == ST_REQ) && !rst;
    assign imem.imem_addr = pc;

    assign instr_valid = (state == ST_HOLD);
    assign halted      = (state == ST_HALT);
    assign instr       = ir;
    assign opcode      = ir[INSTR_W-1 -: 4];

    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that leave it untouched.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        case (state)
            ST_REQ: begin
                // The request still goes out; its data is dropped via pending.
                state_next = ST_WAIT;
                if (redirect_valid) begin
                    pc_load      = 1'b1;
                    pending_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_load      = 1'b1;
                    pending_next = 1'b1;
                end
                if (imem.imem_rvalid) begin
                    if (pending || redirect_valid) begin
                        pending_next = 1'b0;
                        state_next   = ST_REQ;
                    end else begin
                        ir_load    = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (instr_ack) begin
                    if (opcode == OP_HALT) begin
                        state_next = ST_HALT;
                    end else begin
                        state_next = ST_REQ;
                        pc_load    = redirect_valid;
                        pc_inc     = !redirect_valid;
                    end
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_REQ;
            pending <= 1'b0;
            ir      <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (ir_load) begin
                ir <= imem.imem_rdata;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // pc_load fires exactly on accepted redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (ir_load) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (pc_load) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wiscsc15_fetch.sv
// Directed bench for wiscsc15_fetch: sequential fetch, redirects in each
// state, halt, mid-fetch reset and PC wrap on a second instance.
module tb_wiscsc15_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance a: RESET_PC = 0
    logic        rst;
    logic        instr_ack;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
    logic [31:0] fetch_count_b;
    logic [31:0] redirect_count_b;
`endif

    // Instance b: RESET_PC = 16'hFFFF
    logic        rst_b;
    logic        instr_ack_b;
    logic        instr_valid_b;
    logic [15:0] instr_b;
    logic [3:0]  opcode_b;
    logic [15:0] pc_b;
    logic [15:0] pc_plus1_b;
    logic        halted_b;

    wiscsc15_fetch_if #(.PC_W(16), .INSTR_W(16)) ifa ();
    wiscsc15_fetch_if #(.PC_W(16), .INSTR_W(16)) ifb ();

    wiscsc15_fetch #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count),
`endif
        .imem           (ifa),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .opcode         (opcode),
        .pc             (pc),
        .pc_plus1       (pc_plus1),
        .instr_ack      (instr_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    wiscsc15_fetch #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF)) dut_b (
        .clk            (clk),
        .rst            (rst_b),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count    (fetch_count_b),
        .redirect_count (redirect_count_b),
`endif
        .imem           (ifb),
        .instr_valid    (instr_valid_b),
        .instr          (instr_b),
        .opcode         (opcode_b),
        .pc             (pc_b),
        .pc_plus1       (pc_plus1_b),
        .instr_ack      (instr_ack_b),
        .redirect_valid (1'b0),
        .redirect_pc    (16'h0000),
        .halted         (halted_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the REQ cycle; returns in the first HOLD cycle with ack low.
    task automatic fetch_a(input string tag, input logic [15:0] addr,
                           input logic [15:0] data, input int lat);
        check({tag, "_req"}, ifa.imem_req, 1'b1);
        check({tag, "_addr"}, ifa.imem_addr, addr);
        for (int i = 1; i <= lat; i++) begin
            step();
            if (i == lat) begin
                ifa.imem_rvalid = 1'b1;
                ifa.imem_rdata  = data;
            end
            check({tag, "_wait_valid"}, instr_valid, 1'b0);
            check({tag, "_wait_req"}, ifa.imem_req, 1'b0);
        end
        step();
        ifa.imem_rvalid = 1'b0;
        ifa.imem_rdata  = 16'h0000;
        check({tag, "_valid"}, instr_valid, 1'b1);
        check({tag, "_instr"}, instr, data);
        check({tag, "_pc"}, pc, addr);
    endtask

    task automatic ack_a(input logic redir, input logic [15:0] target);
        instr_ack      = 1'b1;
        redirect_valid = redir;
        redirect_pc    = target;
        step();
        instr_ack      = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        instr_ack       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 16'h0000;
        ifa.imem_rvalid = 1'b0;
        ifa.imem_rdata  = 16'h0000;
        rst_b           = 1'b1;
        instr_ack_b     = 1'b0;
        ifb.imem_rvalid = 1'b0;
        ifb.imem_rdata  = 16'h0000;
        step();
        step();

        // Reset state
        check("rst_req", ifa.imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", pc, 16'h0000);
        check("rst_instr", instr, 16'h0000);

        // Sequential fetch, L=1
        rst = 1'b0;
        #1;
        fetch_a("seq0", 16'h0000, 16'h1234, 1);
        check("seq0_opcode", opcode, 4'h1);
        check("seq0_pc_plus1", pc_plus1, 16'h0001);
        ack_a(1'b0, 16'h0000);
        check("seq0_ack_valid", instr_valid, 1'b0);
        fetch_a("seq1", 16'h0001, 16'h2345, 1);
        check("seq1_opcode", opcode, 4'h2);
        ack_a(1'b0, 16'h0000);
        fetch_a("seq2", 16'h0002, 16'h0000, 1);
        ack_a(1'b0, 16'h0000);

        // Redirect in HOLD; a redirect without ack is ignored
        fetch_a("hold", 16'h0003, 16'hC005, 1);
        check("hold_pc_plus1", pc_plus1, 16'h0004);
        check("hold_opcode", opcode, 4'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0077;
        step();
        redirect_valid = 1'b0;
        check("noack_valid", instr_valid, 1'b1);
        check("noack_pc", pc, 16'h0003);
        ack_a(1'b1, 16'h0040);
        check("hold_redir_req", ifa.imem_req, 1'b1);
        check("hold_redir_addr", ifa.imem_addr, 16'h0040);

        // Redirect in WAIT with L=4, asserted one cycle after the request
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        check("wredir_valid0", instr_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        check("wredir_pc", pc, 16'h0100);
        step();
        step();
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = 16'h5555;
        step();
        ifa.imem_rvalid = 1'b0;
        check("wredir_drop_valid", instr_valid, 1'b0);
        check("wredir_req", ifa.imem_req, 1'b1);
        check("wredir_addr", ifa.imem_addr, 16'h0100);

        // Redirect and rvalid in the same WAIT cycle: redirect wins
        step();
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = 16'h7777;
        redirect_valid  = 1'b1;
        redirect_pc     = 16'h0200;
        step();
        ifa.imem_rvalid = 1'b0;
        redirect_valid  = 1'b0;
        check("same_valid", instr_valid, 1'b0);
        check("same_addr", ifa.imem_addr, 16'h0200);

        // Redirect in REQ: the request completes at the old address
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0300;
        check("rreq_req", ifa.imem_req, 1'b1);
        check("rreq_addr_old", ifa.imem_addr, 16'h0200);
        step();
        redirect_valid  = 1'b0;
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = 16'h8888;
        check("rreq_wait_valid", instr_valid, 1'b0);
        step();
        ifa.imem_rvalid = 1'b0;
        check("rreq_drop_valid", instr_valid, 1'b0);
        check("rreq_new_addr", ifa.imem_addr, 16'h0300);

        // rvalid in REQ and HOLD is ignored; then HALT
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = 16'h9999;
        step();
        ifa.imem_rdata  = 16'hF000;
        check("req_rvalid_ignored", instr_valid, 1'b0);
        step();
        ifa.imem_rdata  = 16'h1111;
        check("halt_instr", instr, 16'hF000);
        check("halt_opcode", opcode, 4'hF);
        step();
        ifa.imem_rvalid = 1'b0;
        check("hold_rvalid_ignored", instr, 16'hF000);
        ack_a(1'b1, 16'h0400);
        check("halted", halted, 1'b1);
        check("halt_valid", instr_valid, 1'b0);
        check("halt_pc", pc, 16'h0300);
        for (int i = 0; i < 3; i++) begin
            check("halt_no_req", ifa.imem_req, 1'b0);
            step();
        end
        check("halt_stays", halted, 1'b1);

        // Reset out of HALT, then reset mid-fetch with a late rvalid
        rst = 1'b1;
        step();
        check("rst2_halted", halted, 1'b0);
        check("rst2_req_gated", ifa.imem_req, 1'b0);
        rst = 1'b0;
        #1;
        check("rst2_req", ifa.imem_req, 1'b1);
        check("rst2_addr", ifa.imem_addr, 16'h0000);
        step();
        step();
        rst = 1'b1;
        step();
        rst             = 1'b0;
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = 16'hABCD;
        #1;
        check("midrst_valid", instr_valid, 1'b0);
        check("midrst_req", ifa.imem_req, 1'b1);
        check("midrst_addr", ifa.imem_addr, 16'h0000);
        step();
        ifa.imem_rvalid = 1'b0;
        check("late_rvalid_valid", instr_valid, 1'b0);
        check("late_rvalid_instr", instr, 16'h0000);
        step();
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = 16'h2222;
        step();
        ifa.imem_rvalid = 1'b0;
        ifa.imem_rdata  = 16'h0000;
        check("post_rst_valid", instr_valid, 1'b1);
        check("post_rst_instr", instr, 16'h2222);

        // Three captures and one redirect since the last reset
        ack_a(1'b0, 16'h0000);
        fetch_a("perf1", 16'h0001, 16'h3333, 2);
        ack_a(1'b1, 16'h0010);
        fetch_a("perf2", 16'h0010, 16'h4444, 1);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, 32'd3);
        check("redirect_count", redirect_count, 32'd1);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst3_valid", instr_valid, 1'b0);
        check("rst3_pc", pc, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count_rst", fetch_count, 32'd0);
        check("redirect_count_rst", redirect_count, 32'd0);
`endif

        // PC wrap on the RESET_PC=16'hFFFF instance
        check("wrap_rst_req", ifb.imem_req, 1'b0);
        rst_b = 1'b0;
        #1;
        check("wrap_req0", ifb.imem_req, 1'b1);
        check("wrap_addr0", ifb.imem_addr, 16'hFFFF);
        step();
        ifb.imem_rvalid = 1'b1;
        ifb.imem_rdata  = 16'h0001;
        step();
        ifb.imem_rvalid = 1'b0;
        check("wrap_valid", instr_valid_b, 1'b1);
        check("wrap_instr", instr_b, 16'h0001);
        check("wrap_opcode", opcode_b, 4'h0);
        check("wrap_pc", pc_b, 16'hFFFF);
        check("wrap_pc_plus1", pc_plus1_b, 16'h0000);
        instr_ack_b = 1'b1;
        step();
        instr_ack_b = 1'b0;
        check("wrap_req1", ifb.imem_req, 1'b1);
        check("wrap_addr1", ifb.imem_addr, 16'h0000);
        check("wrap_halted", halted_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
